maj_serial_adder_arbiter: RTL and testbench

- Shares one bit-serial majority-gate full-adder slice between two requesters.
- The slice is the three-input-majority (Tougaw) formulation.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Sits between operand producers and the result consumer. It is the time-multiplexed alternative to instantiating a WIDTH-bit ripple chain of majority adders.

---
 rtl/maj_serial_adder_arbiter.sv | 143 ++++++++++++++
 tb/tb_maj_serial_adder_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_serial_adder_arbiter.sv
// Two-requester front end sharing one bit-serial majority-gate full-adder slice.
// Round-robin grant in IDLE, WIDTH bit-serial steps in RUN, result held in DONE
// until the consumer takes it. Result registers keep their value after DONE.
module maj_serial_adder_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic [WIDTH-1:0] rsp_carry,
    output logic             rsp_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_grant_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               c_q;
    logic               id_q;
    logic [WIDTH-1:0]   sum_w_q;
    logic [WIDTH-1:0]   carry_w_q;
    logic [WIDTH-1:0]   sum_o_q;
    logic [WIDTH-1:0]   carry_o_q;
    logic               id_o_q;

    logic               grant0;
    logic               grant1;
    logic               ak;
    logic               bk;
    logic               cout_k;
    logic               sum_k;
    logic [WIDTH-1:0]   sum_nx;
    logic [WIDTH-1:0]   carry_nx;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Round-robin grant: on a tie the requester not served last time wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
        // Gated by rst_n so ready reads 0 while reset is held.
        req0_ready = rst_n & (state_q == StIdle) & grant0;
        req1_ready = rst_n & (state_q == StIdle) & grant1;
    end

    // Majority-only full-adder slice on the current LSBs, results shifted in at the MSB.
    always_comb begin
        ak       = a_q[0];
        bk       = b_q[0];
        cout_k   = maj(ak, bk, c_q);
        sum_k    = maj(maj(~ak, bk, c_q), maj(ak, bk, ~c_q), maj(ak, ~bk, c_q));
        sum_nx   = (sum_w_q >> 1) | (WIDTH'(sum_k) << (WIDTH - 1));
        carry_nx = (carry_w_q >> 1) | (WIDTH'(cout_k) << (WIDTH - 1));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= 1'b0;
            id_q         <= 1'b0;
            sum_w_q      <= '0;
            carry_w_q    <= '0;
            sum_o_q      <= '0;
            carry_o_q    <= '0;
            id_o_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0_ready || req1_ready) begin
                        a_q          <= req1_ready ? req1_a : req0_a;
                        b_q          <= req1_ready ? req1_b : req0_b;
                        c_q          <= req1_ready ? req1_cin : req0_cin;
                        id_q         <= req1_ready;
                        last_grant_q <= req1_ready;
                        cnt_q        <= '0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    a_q       <= a_q >> 1;
                    b_q       <= b_q >> 1;
                    c_q       <= cout_k;
                    sum_w_q   <= sum_nx;
                    carry_w_q <= carry_nx;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Publish the finished result; it stays put until the next op ends.
                        sum_o_q   <= sum_nx;
                        carry_o_q <= carry_nx;
                        id_o_q    <= id_q;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Response outputs come straight from registers.
    always_comb begin
        rsp_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        rsp_id    = id_o_q;
        rsp_sum   = sum_o_q;
        rsp_carry = carry_o_q;
        rsp_cout  = carry_o_q[WIDTH-1];
    end

endmodule

// File: tb/tb_maj_serial_adder_arbiter.sv
// Directed and randomized checks of the shared majority serial adder.
module tb_maj_serial_adder_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_cin = 1'b0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_cin = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic [WIDTH-1:0] rsp_carry;
    logic             rsp_cout;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    maj_serial_adder_arbiter #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Carry out of bit i = bit i+1 of the partial sum over bits i..0.
    function automatic logic [WIDTH-1:0] model_carry(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic cin);
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   m;
        logic [WIDTH:0]   p;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m = (WIDTH+1)'((1 << (i + 1)) - 1);
            p = ({1'b0, a} & m) + ({1'b0, b} & m) + {{WIDTH{1'b0}}, cin};
            r[i] = p[i+1];
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One operation on one requester; all expected values come from the caller.
    task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input int stall, input logic [WIDTH-1:0] es,
                          input logic [WIDTH-1:0] ec, input logic eco);
        int lat;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        rsp_ready = 1'b0;
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL op_ready: got %b want %b", {req1_ready, req0_ready},
                     id ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if (lat != WIDTH) begin
            n_err++;
            $display("FAIL op_latency: got %0d want %0d", lat, WIDTH);
        end
        n_vec++;
        if ({rsp_id, rsp_sum, rsp_carry, rsp_cout} !== {id, es, ec, eco}) begin
            n_err++;
            $display("FAIL op_result: got id=%b sum=%b carry=%b cout=%b want id=%b sum=%b carry=%b cout=%b",
                     rsp_id, rsp_sum, rsp_carry, rsp_cout, id, es, ec, eco);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout} !== {1'b1, id, es, ec, eco}) begin
                n_err++;
                $display("FAIL op_stall_hold: got v=%b id=%b sum=%b carry=%b cout=%b",
                         rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL op_release: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got r0=%b r1=%b v=%b id=%b sum=%b carry=%b cout=%b busy=%b want all 0",
                     req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout, busy);
        end
    endtask

    task automatic test_single_add();
        run_op(1'b0, 4'b0011, 4'b0101, 1'b0, 0, 4'b1000, 4'b0111, 1'b0);
    endtask

    task automatic test_overflow();
        run_op(1'b1, 4'b1111, 4'b0000, 1'b1, 0, 4'b0000, 4'b1111, 1'b1);
        run_op(1'b1, 4'b0000, 4'b0000, 1'b1, 1, 4'b0001, 4'b0000, 1'b0);
    endtask

    task automatic test_contention();
        int order[4] = '{0, 1, 0, 1};
        int acc = 0;
        int last_acc = 0;
        int resp = 0;
        int cyc = 0;
        logic [WIDTH-1:0] es;
        logic [WIDTH-1:0] ec;
        logic eco;
        do_reset();
        req0_a = 4'b0011; req0_b = 4'b0101; req0_cin = 1'b0;
        req1_a = 4'b1001; req1_b = 4'b0111; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        while (acc < 4 && cyc < 60) begin
            n_vec++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                n_err++;
                $display("FAIL cont_both_ready: got 11 want at most one high");
            end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                n_vec++;
                if (int'(req1_ready) != order[acc] || (acc > 0 && cyc - last_acc != 6)) begin
                    n_err++;
                    $display("FAIL cont_grant: got id=%0d gap=%0d want id=%0d gap=6",
                             req1_ready, cyc - last_acc, order[acc]);
                end
                last_acc = cyc;
                acc++;
            end
            if (rsp_valid === 1'b1) begin
                // req0: 3+5+0 = 8; req1: 9+7+1 = 17
                es  = (order[resp] == 1) ? 4'b0001 : 4'b1000;
                ec  = (order[resp] == 1) ? 4'b1111 : 4'b0111;
                eco = (order[resp] == 1);
                n_vec++;
                if ({rsp_id, rsp_sum, rsp_carry, rsp_cout} !== {order[resp] == 1, es, ec, eco}) begin
                    n_err++;
                    $display("FAIL cont_result: got id=%b sum=%b carry=%b cout=%b want id=%0d sum=%b carry=%b cout=%b",
                             rsp_id, rsp_sum, rsp_carry, rsp_cout, order[resp], es, ec, eco);
                end
                resp++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++;
        if (acc != 4 || resp != 3) begin
            n_err++;
            $display("FAIL cont_progress: got accepts=%0d responses=%0d want 4 3", acc, resp);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat = 0;
        do_reset();
        req0_a = 4'b0011; req0_b = 4'b0101; req0_cin = 1'b0;
        req1_a = 4'b1111; req1_b = 4'b0000; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        @(posedge clk);
        #1;
        while (rsp_valid !== 1'b1 && lat < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_sum, rsp_carry, rsp_cout}
                !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold: got v=%b busy=%b r0=%b r1=%b id=%b sum=%b carry=%b cout=%b",
                         rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_sum, rsp_carry, rsp_cout);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_sum} !== {4'b0001, 4'b1000}) begin
            n_err++;
            $display("FAIL bp_after_handshake: got v=%b busy=%b r0=%b r1=%b sum=%b want 0 0 0 1 1000",
                     rsp_valid, busy, req0_ready, req1_ready, rsp_sum);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next_accept: got busy=%b want 1", busy);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout} !== {1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second: got v=%b id=%b sum=%b carry=%b cout=%b want 1 1 0000 1111 1",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat = 0;
        req0_a = 4'b0110; req0_b = 4'b0011; req0_cin = 1'b1;
        req1_a = 4'b0001; req1_b = 4'b0001; req1_cin = 1'b0;
        req0_valid = 1'b1;
        #1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout, busy} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got r0=%b r1=%b v=%b id=%b sum=%b carry=%b cout=%b busy=%b want all 0",
                     req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout, busy);
        end
        for (int s = 0; s < 6; s++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_response: got rsp_valid=%b want 0", rsp_valid);
            end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_rearb: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        // 6 + 3 + 1 = 10
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout} !== {1'b1, 1'b0, 4'b1010, 4'b0111, 1'b0}) begin
            n_err++;
            $display("FAIL rst_after: got v=%b id=%b sum=%b carry=%b cout=%b want 1 0 1010 0111 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_cout);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             id;
        logic [WIDTH:0]   tot;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            a   = WIDTH'($urandom_range(15, 0));
            b   = WIDTH'($urandom_range(15, 0));
            cin = 1'($urandom_range(1, 0));
            id  = 1'($urandom_range(1, 0));
            tot = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            run_op(id, a, b, cin, int'($urandom_range(3, 0)), tot[WIDTH-1:0],
                   model_carry(a, b, cin), tot[WIDTH]);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
